// File: rtl/rs_param_pkg.sv
// rtl/rs_param_pkg.sv - shared widths, NOP opcode and entry layout for the reservation station
package rs_pkg;

  localparam int RS_XLEN  = 32;
  localparam int RS_ROB_W = 6;
  localparam int RS_OP_W  = 6;

  localparam logic [RS_OP_W-1:0] OP_NOP = '0;

  typedef struct packed {
    logic                busy;
    logic [RS_OP_W-1:0]  opcode;
    logic [RS_ROB_W-1:0] rob_index;
    logic [RS_XLEN-1:0]  val1;
    logic [RS_ROB_W-1:0] dep1;
    logic                has_dep1;
    logic [RS_XLEN-1:0]  val2;
    logic [RS_ROB_W-1:0] dep2;
    logic                has_dep2;
    logic [RS_XLEN-1:0]  imm;
    logic [RS_XLEN-1:0]  pc;
  } rs_entry_t;

endpackage

// File: rtl/rs_param_if.sv
// rtl/rs_param_if.sv - issue, result-broadcast and dispatch signals of the reservation station
interface rs_param_if
  import rs_pkg::*;
#(
  parameter int XLEN    = RS_XLEN,
  parameter int ROB_W   = RS_ROB_W,
  parameter int OP_W    = RS_OP_W,
  parameter int NUM_CDB = 2
);

  logic                     issue_valid;
  logic [OP_W-1:0]          issue_opcode;
  logic [XLEN-1:0]          issue_val1;
  logic [XLEN-1:0]          issue_val2;
  logic [ROB_W-1:0]         issue_dep1;
  logic [ROB_W-1:0]         issue_dep2;
  logic                     issue_has_dep1;
  logic                     issue_has_dep2;
  logic [ROB_W-1:0]         issue_rob_index;
  logic [XLEN-1:0]          issue_imm;
  logic [XLEN-1:0]          issue_pc;

  logic [NUM_CDB-1:0]       cdb_valid;
  logic [NUM_CDB*ROB_W-1:0] cdb_rob_index;
  logic [NUM_CDB*XLEN-1:0]  cdb_value;

  logic                     exe_ready;
  logic                     exe_valid;
  logic [OP_W-1:0]          exe_opcode;
  logic [XLEN-1:0]          exe_val1;
  logic [XLEN-1:0]          exe_val2;
  logic [XLEN-1:0]          exe_imm;
  logic [XLEN-1:0]          exe_pc;
  logic [ROB_W-1:0]         exe_rob_index;

  modport master (
    output issue_valid, issue_opcode, issue_val1, issue_val2, issue_dep1, issue_dep2,
           issue_has_dep1, issue_has_dep2, issue_rob_index, issue_imm, issue_pc,
           cdb_valid, cdb_rob_index, cdb_value, exe_ready,
    input  exe_valid, exe_opcode, exe_val1, exe_val2, exe_imm, exe_pc, exe_rob_index
  );

  modport slave (
    input  issue_valid, issue_opcode, issue_val1, issue_val2, issue_dep1, issue_dep2,
           issue_has_dep1, issue_has_dep2, issue_rob_index, issue_imm, issue_pc,
           cdb_valid, cdb_rob_index, cdb_value, exe_ready,
    output exe_valid, exe_opcode, exe_val1, exe_val2, exe_imm, exe_pc, exe_rob_index
  );

endinterface

// File: rtl/rs_param_age_select.sv
// rtl/rs_param_age_select.sv - one-hot grant of the oldest ready entry from the age matrix
module rs_age_select #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  input  logic [DEPTH-1:0]            ready,
  output logic [DEPTH-1:0]            grant,
  output logic                        any_ready
);

  // age[e][j] set means j entered before e; e wins only if no older entry is ready
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      grant[e] = ready[e] & ~(|(age[e] & ready));
    end
  end

  assign any_ready = |ready;

endmodule

// File: rtl/rs_param.sv
// rtl/rs_param.sv - parametrised reservation station: wake-up, issue bypass, oldest-first dispatch
module rs_param
  import rs_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int XLEN        = RS_XLEN,
  parameter int ROB_W       = RS_ROB_W,
  parameter int OP_W        = RS_OP_W,
  parameter int NUM_CDB     = 2,
  parameter int FULL_MARGIN = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       flush,
  rs_param_if.slave                  bus,
  output logic [$clog2(DEPTH+1)-1:0] rs_count,
  output logic                       rs_full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0]            busy;
  logic [DEPTH-1:0]            has_dep1;
  logic [DEPTH-1:0]            has_dep2;
  logic [DEPTH-1:0][DEPTH-1:0] age;

  logic [OP_W-1:0]  opcode_q [DEPTH];
  logic [ROB_W-1:0] rob_q    [DEPTH];
  logic [XLEN-1:0]  val1_q   [DEPTH];
  logic [XLEN-1:0]  val2_q   [DEPTH];
  logic [ROB_W-1:0] dep1_q   [DEPTH];
  logic [ROB_W-1:0] dep2_q   [DEPTH];
  logic [XLEN-1:0]  imm_q    [DEPTH];
  logic [XLEN-1:0]  pc_q     [DEPTH];

  logic             exe_valid_q;
  logic [OP_W-1:0]  exe_opcode_q;
  logic [XLEN-1:0]  exe_val1_q;
  logic [XLEN-1:0]  exe_val2_q;
  logic [XLEN-1:0]  exe_imm_q;
  logic [XLEN-1:0]  exe_pc_q;
  logic [ROB_W-1:0] exe_rob_q;

  logic [DEPTH-1:0] ready, grant, freed;
  logic             any_ready, adv, do_disp, do_issue, alloc_ok;
  logic [IDX_W-1:0] alloc_idx, grant_idx;
  logic [DEPTH-1:0] hit1, hit2;
  logic [XLEN-1:0]  wval1 [DEPTH];
  logic [XLEN-1:0]  wval2 [DEPTH];
  logic             byp1, byp2;
  logic [XLEN-1:0]  byp_val1, byp_val2;

  assign ready = busy & ~has_dep1 & ~has_dep2;

  rs_age_select #(.DEPTH(DEPTH)) u_age_select (
    .age       (age),
    .ready     (ready),
    .grant     (grant),
    .any_ready (any_ready)
  );

  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!busy[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) grant_idx = IDX_W'(i);
    end
  end

  // Channels are scanned high to low so the lowest matching channel has the final say
  always_comb begin
    byp1     = 1'b0;
    byp2     = 1'b0;
    byp_val1 = '0;
    byp_val2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i]  = 1'b0;
      hit2[i]  = 1'b0;
      wval1[i] = '0;
      wval2[i] = '0;
    end
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (bus.cdb_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (bus.cdb_rob_index[k*ROB_W +: ROB_W] == dep1_q[i]) begin
            hit1[i]  = 1'b1;
            wval1[i] = bus.cdb_value[k*XLEN +: XLEN];
          end
          if (bus.cdb_rob_index[k*ROB_W +: ROB_W] == dep2_q[i]) begin
            hit2[i]  = 1'b1;
            wval2[i] = bus.cdb_value[k*XLEN +: XLEN];
          end
        end
        if (bus.cdb_rob_index[k*ROB_W +: ROB_W] == bus.issue_dep1) begin
          byp1     = 1'b1;
          byp_val1 = bus.cdb_value[k*XLEN +: XLEN];
        end
        if (bus.cdb_rob_index[k*ROB_W +: ROB_W] == bus.issue_dep2) begin
          byp2     = 1'b1;
          byp_val2 = bus.cdb_value[k*XLEN +: XLEN];
        end
      end
    end
  end

  assign adv      = !exe_valid_q || bus.exe_ready;
  assign do_disp  = adv && any_ready;
  assign do_issue = bus.issue_valid && alloc_ok;
  assign freed    = do_disp ? grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= '0;
      has_dep1     <= '0;
      has_dep2     <= '0;
      age          <= '0;
      rs_count     <= '0;
      exe_valid_q  <= 1'b0;
      exe_opcode_q <= '0;
      exe_val1_q   <= '0;
      exe_val2_q   <= '0;
      exe_imm_q    <= '0;
      exe_pc_q     <= '0;
      exe_rob_q    <= '0;
    end else if (rdy) begin
      if (flush) begin
        busy        <= '0;
        has_dep1    <= '0;
        has_dep2    <= '0;
        age         <= '0;
        rs_count    <= '0;
        exe_valid_q <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy[i] && has_dep1[i] && hit1[i]) has_dep1[i] <= 1'b0;
          if (busy[i] && has_dep2[i] && hit2[i]) has_dep2[i] <= 1'b0;
          if (freed[i]) busy[i] <= 1'b0;
          for (int r = 0; r < DEPTH; r++) begin
            if (freed[i]) age[r][i] <= 1'b0;
          end
        end
        if (do_disp) begin
          exe_valid_q  <= 1'b1;
          exe_opcode_q <= opcode_q[grant_idx];
          exe_val1_q   <= val1_q[grant_idx];
          exe_val2_q   <= val2_q[grant_idx];
          exe_imm_q    <= imm_q[grant_idx];
          exe_pc_q     <= pc_q[grant_idx];
          exe_rob_q    <= rob_q[grant_idx];
        end else if (adv) begin
          exe_valid_q <= 1'b0;
        end
        if (do_issue) begin
          busy[alloc_idx]     <= 1'b1;
          has_dep1[alloc_idx] <= bus.issue_has_dep1 && !byp1;
          has_dep2[alloc_idx] <= bus.issue_has_dep2 && !byp2;
          age[alloc_idx]      <= busy & ~freed;
        end
        rs_count <= rs_count + CNT_W'(do_issue) - CNT_W'(do_disp);
      end
    end
  end

  // Payload carries no reset: it is only ever read behind busy/has_dep
  always_ff @(posedge clk) begin
    if (rdy && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i] && has_dep1[i] && hit1[i]) val1_q[i] <= wval1[i];
        if (busy[i] && has_dep2[i] && hit2[i]) val2_q[i] <= wval2[i];
      end
      if (do_issue) begin
        opcode_q[alloc_idx] <= bus.issue_opcode;
        rob_q[alloc_idx]    <= bus.issue_rob_index;
        dep1_q[alloc_idx]   <= bus.issue_dep1;
        dep2_q[alloc_idx]   <= bus.issue_dep2;
        val1_q[alloc_idx]   <= (bus.issue_has_dep1 && byp1) ? byp_val1 : bus.issue_val1;
        val2_q[alloc_idx]   <= (bus.issue_has_dep2 && byp2) ? byp_val2 : bus.issue_val2;
        imm_q[alloc_idx]    <= bus.issue_imm;
        pc_q[alloc_idx]     <= bus.issue_pc;
      end
    end
  end

  assign bus.exe_valid     = exe_valid_q;
  assign bus.exe_opcode    = exe_opcode_q;
  assign bus.exe_val1      = exe_val1_q;
  assign bus.exe_val2      = exe_val2_q;
  assign bus.exe_imm       = exe_imm_q;
  assign bus.exe_pc        = exe_pc_q;
  assign bus.exe_rob_index = exe_rob_q;

  assign rs_full = (DEPTH - int'(rs_count)) <= FULL_MARGIN;

endmodule

// File: tb/tb_rs_param.sv
// tb/tb_rs_param.sv - randomized and directed bench for rs_param against an in-order list model
module tb_rs_param;
  import rs_pkg::*;

  localparam int DEPTH   = 16;
  localparam int XLEN    = 32;
  localparam int ROB_W   = 6;
  localparam int OP_W    = 6;
  localparam int NUM_CDB = 2;
  localparam int VW      = 1 + OP_W + ROB_W + 4*XLEN + 5 + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdy = 1'b1;
  logic       flush = 1'b0;
  logic [4:0] rs_count;
  logic       rs_full;

  always #5 clk = ~clk;

  rs_param_if #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .NUM_CDB(NUM_CDB)) bus ();

  rs_param #(
    .DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W),
    .NUM_CDB(NUM_CDB), .FULL_MARGIN(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .bus      (bus),
    .rs_count (rs_count),
    .rs_full  (rs_full)
  );

  int errors = 0;
  int checks = 0;

  // Model: entries kept in issue order, so the oldest ready one is the first ready in the list
  rs_entry_t        m_q[$];
  logic             m_valid;
  logic [OP_W-1:0]  m_op;
  logic [ROB_W-1:0] m_rob;
  logic [XLEN-1:0]  m_val1, m_val2, m_imm, m_pc;

  function automatic logic [VW-1:0] act_vec();
    return {bus.exe_valid, bus.exe_opcode, bus.exe_rob_index, bus.exe_val1, bus.exe_val2,
            bus.exe_imm, bus.exe_pc, rs_count, rs_full};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic full;
    full = (DEPTH - m_q.size()) <= 1;
    return {m_valid, m_op, m_rob, m_val1, m_val2, m_imm, m_pc, 5'(m_q.size()), full};
  endfunction

  function automatic bit cdb_match(input logic [ROB_W-1:0] dep, output logic [XLEN-1:0] v);
    v = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (bus.cdb_valid[k] && bus.cdb_rob_index[k*ROB_W +: ROB_W] == dep) begin
        v = bus.cdb_value[k*XLEN +: XLEN];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_op = '0; m_rob = '0; m_val1 = '0; m_val2 = '0; m_imm = '0; m_pc = '0;
  endtask

  task automatic model_step();
    rs_entry_t        e;
    logic [XLEN-1:0]  v;
    int               sel;
    bit               can_issue;
    if (!rdy) return;
    if (flush) begin
      m_q.delete();
      m_valid = 1'b0;
      return;
    end
    can_issue = m_q.size() < DEPTH;
    if (!m_valid || bus.exe_ready) begin
      sel = -1;
      for (int i = 0; i < m_q.size(); i++)
        if (sel < 0 && !m_q[i].has_dep1 && !m_q[i].has_dep2) sel = i;
      if (sel >= 0) begin
        e = m_q[sel];
        m_valid = 1'b1;
        m_op = e.opcode; m_rob = e.rob_index; m_val1 = e.val1; m_val2 = e.val2;
        m_imm = e.imm; m_pc = e.pc;
        m_q.delete(sel);
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < m_q.size(); i++) begin
      e = m_q[i];
      if (e.has_dep1 && cdb_match(e.dep1, v)) begin e.val1 = v; e.has_dep1 = 1'b0; end
      if (e.has_dep2 && cdb_match(e.dep2, v)) begin e.val2 = v; e.has_dep2 = 1'b0; end
      m_q[i] = e;
    end
    if (bus.issue_valid && can_issue) begin
      e.busy = 1'b1;
      e.opcode = bus.issue_opcode; e.rob_index = bus.issue_rob_index;
      e.val1 = bus.issue_val1; e.dep1 = bus.issue_dep1; e.has_dep1 = bus.issue_has_dep1;
      e.val2 = bus.issue_val2; e.dep2 = bus.issue_dep2; e.has_dep2 = bus.issue_has_dep2;
      e.imm = bus.issue_imm; e.pc = bus.issue_pc;
      if (e.has_dep1 && cdb_match(e.dep1, v)) begin e.val1 = v; e.has_dep1 = 1'b0; end
      if (e.has_dep2 && cdb_match(e.dep2, v)) begin e.val2 = v; e.has_dep2 = 1'b0; end
      m_q.push_back(e);
    end
  endtask

  task automatic tick();
    if (!rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.issue_has_dep1 = 1'b0;
    bus.issue_has_dep2 = 1'b0;
    bus.cdb_valid = '0;
  endtask

  task automatic set_issue(input int rob, input bit hd1, input int d1, input bit hd2, input int d2);
    bus.issue_valid     = 1'b1;
    bus.issue_opcode    = OP_W'($urandom_range(1, 63));
    bus.issue_rob_index = ROB_W'(rob);
    bus.issue_val1      = $urandom;
    bus.issue_val2      = $urandom;
    bus.issue_dep1      = ROB_W'(d1);
    bus.issue_dep2      = ROB_W'(d2);
    bus.issue_has_dep1  = hd1;
    bus.issue_has_dep2  = hd2;
    bus.issue_imm       = $urandom;
    bus.issue_pc        = $urandom;
  endtask

  task automatic set_cdb(input int ch, input int rob, input logic [XLEN-1:0] v);
    bus.cdb_valid[ch] = 1'b1;
    bus.cdb_rob_index[ch*ROB_W +: ROB_W] = ROB_W'(rob);
    bus.cdb_value[ch*XLEN +: XLEN] = v;
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.exe_ready = 1'b0; idle();
    bus.cdb_rob_index = '0; bus.cdb_value = '0;
    tick(); tick();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_state act=%h exp=%h", act_vec(), exp_vec());
    end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_issue(i + 1, i != 0, 20, 1'b0, 0);
      tick();
    end
    idle();
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++; $display("FAIL pre_reset act=%h exp=%h", act_vec(), exp_vec());
    end
    #2 rst = 1'b0;
    #1 model_reset();
    checks++;
    if (bus.exe_valid !== 1'b0 || rs_count !== 5'd0) begin
      errors++; $display("FAIL async_reset valid=%b count=%0d exp valid=0 count=0", bus.exe_valid, rs_count);
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec() || bus.exe_valid !== 1'b0) begin
        errors++; $display("FAIL idle_after_reset act=%h exp=%h", act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_oldest_first();
    bus.exe_ready = 1'b1;
    set_issue(3, 1'b1, 9, 1'b0, 0); tick();
    set_issue(4, 1'b0, 0, 1'b0, 0); tick();
    set_issue(5, 1'b0, 0, 1'b0, 0); tick();
    idle();
    checks++;
    if (act_vec() !== exp_vec() || bus.exe_valid !== 1'b1 || bus.exe_rob_index !== 6'd4) begin
      errors++; $display("FAIL oldest_first_rob4 act=%h exp=%h", act_vec(), exp_vec());
    end
    tick();
    checks++;
    if (act_vec() !== exp_vec() || bus.exe_rob_index !== 6'd5) begin
      errors++; $display("FAIL oldest_first_rob5 act=%h exp=%h", act_vec(), exp_vec());
    end
    tick();
    set_cdb(1, 9, 32'hDEAD); tick(); idle();
    checks++;
    if (act_vec() !== exp_vec() || bus.exe_valid !== 1'b0) begin
      errors++; $display("FAIL wake_not_yet act=%h exp=%h", act_vec(), exp_vec());
    end
    tick();
    checks++;
    if (act_vec() !== exp_vec() || bus.exe_rob_index !== 6'd3 || bus.exe_val1 !== 32'hDEAD) begin
      errors++; $display("FAIL wakeup_dispatch rob=%0d val1=%h exp rob=3 val1=dead", bus.exe_rob_index, bus.exe_val1);
    end
    tick();
  endtask

  task automatic test_bypass();
    bus.exe_ready = 1'b1;
    set_issue(10, 1'b1, 7, 1'b0, 0); set_cdb(0, 7, 32'h1234); tick(); idle(); tick();
    checks++;
    if (act_vec() !== exp_vec() || bus.exe_rob_index !== 6'd10 || bus.exe_val1 !== 32'h1234) begin
      errors++; $display("FAIL bypass val1=%h rob=%0d exp val1=1234 rob=10", bus.exe_val1, bus.exe_rob_index);
    end
    set_issue(11, 1'b0, 0, 1'b1, 12); set_cdb(0, 12, 32'hAAAA0000); set_cdb(1, 12, 32'hBBBB0000);
    tick(); idle(); tick();
    checks++;
    if (act_vec() !== exp_vec() || bus.exe_val2 !== 32'hAAAA0000) begin
      errors++; $display("FAIL bypass_low_channel val2=%h exp=aaaa0000", bus.exe_val2);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus.exe_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_issue(20 + i, 1'b0, 0, 1'b0, 0); tick();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec() || rs_count !== 5'd2 || bus.exe_rob_index !== 6'd20) begin
        errors++; $display("FAIL backpressure_hold cyc=%0d count=%0d rob=%0d exp count=2 rob=20", i, rs_count, bus.exe_rob_index);
      end
    end
    bus.exe_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec() || rs_count !== 5'(1 - (i > 1 ? 1 : i))) begin
        errors++; $display("FAIL backpressure_drain cyc=%0d act=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full();
    bus.exe_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      set_issue(i, 1'b1, 30, 1'b0, 0); tick();
      if (i == 13) begin
        checks++;
        if (act_vec() !== exp_vec() || rs_full !== 1'b0) begin
          errors++; $display("FAIL not_full_14 full=%b count=%0d exp full=0 count=14", rs_full, rs_count);
        end
      end
    end
    checks++;
    if (act_vec() !== exp_vec() || rs_full !== 1'b1 || rs_count !== 5'd15) begin
      errors++; $display("FAIL full_15 full=%b count=%0d exp full=1 count=15", rs_full, rs_count);
    end
    set_issue(40, 1'b1, 31, 1'b0, 0); set_cdb(0, 30, 32'h5555); tick(); idle();
    checks++;
    if (act_vec() !== exp_vec() || rs_count !== 5'd16) begin
      errors++; $display("FAIL full_16 count=%0d exp=16", rs_count);
    end
    set_issue(41, 1'b1, 31, 1'b0, 0); tick();
    checks++;
    if (act_vec() !== exp_vec() || rs_count !== 5'd15 || bus.exe_rob_index !== 6'd0) begin
      errors++; $display("FAIL full_drop count=%0d rob=%0d exp count=15 rob=0", rs_count, bus.exe_rob_index);
    end
    set_issue(42, 1'b1, 31, 1'b0, 0); tick(); idle();
    checks++;
    if (act_vec() !== exp_vec() || rs_count !== 5'd15 || bus.exe_rob_index !== 6'd1) begin
      errors++; $display("FAIL issue_and_dispatch count=%0d rob=%0d exp count=15 rob=1", rs_count, bus.exe_rob_index);
    end
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic test_flush();
    bus.exe_ready = 1'b0;
    set_issue(50, 1'b0, 0, 1'b0, 0); tick();
    for (int i = 0; i < 6; i++) begin
      set_issue(51 + i, 1'b1, 60, 1'b0, 0); tick();
    end
    checks++;
    if (act_vec() !== exp_vec() || rs_count !== 5'd6 || bus.exe_valid !== 1'b1) begin
      errors++; $display("FAIL pre_flush count=%0d valid=%b exp count=6 valid=1", rs_count, bus.exe_valid);
    end
    flush = 1'b1; set_issue(57, 1'b0, 0, 1'b0, 0); tick(); flush = 1'b0; idle();
    checks++;
    if (act_vec() !== exp_vec() || rs_count !== 5'd0 || bus.exe_valid !== 1'b0) begin
      errors++; $display("FAIL flush count=%0d valid=%b exp count=0 valid=0", rs_count, bus.exe_valid);
    end
    tick();
    checks++;
    if (act_vec() !== exp_vec() || rs_count !== 5'd0 || bus.exe_valid !== 1'b0) begin
      errors++; $display("FAIL flush_issue_discarded count=%0d valid=%b exp 0/0", rs_count, bus.exe_valid);
    end
  endtask

  task automatic test_rdy_freeze();
    bus.exe_ready = 1'b1;
    set_issue(70, 1'b0, 0, 1'b0, 0); rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec() || rs_count !== 5'd0) begin
        errors++; $display("FAIL rdy_freeze cyc=%0d count=%0d exp=0", i, rs_count);
      end
    end
    rdy = 1'b1; tick(); idle(); tick();
    checks++;
    if (act_vec() !== exp_vec() || bus.exe_rob_index !== 6'd6 || bus.exe_valid !== 1'b1) begin
      errors++; $display("FAIL rdy_resume rob=%0d valid=%b exp rob=6 valid=1", bus.exe_rob_index, bus.exe_valid);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 59) == 0);
      bus.exe_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, (m_q.size() >= DEPTH - 1) ? 7 : 1) == 0)
        set_issue($urandom_range(0, 63), 1'($urandom), $urandom_range(0, 7),
                  1'($urandom), $urandom_range(0, 7));
      for (int k = 0; k < NUM_CDB; k++)
        if ($urandom_range(0, 2) == 0) set_cdb(k, $urandom_range(0, 7), $urandom);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d act=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
    idle(); rdy = 1'b1; flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_oldest_first();
    test_bypass();
    test_backpressure();
    test_full();
    test_flush();
    test_rdy_freeze();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rs_param.md
Name: rs_param

Overview:
- Parametrised reservation station; successor to the fixed 16-entry ALU station.
- Sits between the issue unit and one execution unit (ALU or branch unit).
- Holds renamed instructions until both operands are available, then dispatches them oldest-first over a valid/ready handshake.
- Snoops NUM_CDB result-broadcast channels for wake-up, bypasses same-cycle broadcasts into newly issued entries, and supports a full flush.

Parameters:
DEPTH, 16, number of entries (power of two not required, >=2)
XLEN, 32, operand/immediate/pc width
ROB_W, 6, ROB index width
OP_W, 6, opcode width
NUM_CDB, 2, number of broadcast channels (ch0 ALU, ch1 LSB)
FULL_MARGIN, 1, rs_full asserts when free entries <= FULL_MARGIN

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
rdy  in  1  global enable; 0 freezes all state
flush  in  1  misprediction flush
issue_valid  in  1  issue request
issue_opcode  in  OP_W  opcode; 0 is never issued
issue_val1 / issue_val2  in  XLEN  operand values
issue_dep1 / issue_dep2  in  ROB_W  producer ROB index
issue_has_dep1 / issue_has_dep2  in  1  operand still pending
issue_rob_index  in  ROB_W  destination ROB index
issue_imm / issue_pc  in  XLEN  immediate, pc
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_rob_index  in  NUM_CDB*ROB_W  packed, channel k at [k*ROB_W +: ROB_W]
cdb_value  in  NUM_CDB*XLEN  packed, channel k at [k*XLEN +: XLEN]
exe_ready  in  1  execution unit accepts
exe_valid  out  1  dispatch valid
exe_opcode  out  OP_W  dispatched opcode
exe_val1 / exe_val2 / exe_imm / exe_pc  out  XLEN  dispatched fields
exe_rob_index  out  ROB_W  dispatched ROB index
rs_count  out  $clog2(DEPTH+1)  occupied entries
rs_full  out  1  free entries <= FULL_MARGIN

Behaviour:
- Reset (rst=0, async): all busy bits, age matrix, has_dep bits and exe_* outputs cleared; rs_count=0; rs_full=0 (unless DEPTH<=FULL_MARGIN).
- rdy=0: no state changes; outputs hold.
- Priority within a cycle: flush > (dispatch, wake-up, issue; these are concurrent).
- flush=1: all busy cleared, exe_valid<=0, rs_count<=0. Same-cycle issue and CDB are ignored.
- Issue:
  - Writes the lowest-index free entry, computed from registered busy.
  - Slot freed by a dispatch in cycle N is allocatable from N+1.
  - issue_valid with no free entry: request dropped, count unchanged. This is a protocol error; the issuer must honour rs_full.
- Issue bypass: if issue_has_depX and some cdb_valid[k] with cdb_rob_index[k]==issue_depX, the entry stores cdb_value[k] with has_depX=0.
- Wake-up:
  - For every busy entry with has_depX=1 and depX matching a valid channel: valX<=value, has_depX<=0.
  - Idle or already-ready entries are never touched.
  - Multiple matching channels: the lowest channel number wins.
- Age: DEPTH x DEPTH age matrix. On issue into e, row e is set to the current busy vector (e is younger than all occupants). Bits are cleared when entries free.
- Ready: busy & ~has_dep1 & ~has_dep2, from registered state. An entry woken at edge N is dispatchable from cycle N+1.
- Dispatch:
  - Advances when !exe_valid || exe_ready.
  - If any entry is ready, the oldest ready entry's fields load into exe_* registers, exe_valid<=1, and the entry is freed. Otherwise exe_valid<=0.
  - If exe_valid && !exe_ready, exe_* hold stable and no entry is freed.
- Minimum latency: issue at edge N with no deps -> exe_valid at edge N+1.
- Throughput: one issue and one dispatch per cycle.
- rs_count updates by +issue_accepted -dispatch_freed each cycle. rs_full is combinational from registered rs_count.

Decomposition:
- rs_pkg holds OP_W, ROB_W and XLEN defaults, the NOP opcode constant (0), and the entry struct typedef {busy, opcode, rob_index, val1, dep1, has_dep1, val2, dep2, has_dep2, imm, pc}.
- One sub-module, rs_age_select: age matrix plus ready vector -> one-hot oldest-ready grant. It is parametrised by DEPTH.

Test Plan:
- Reset/idle: rst=0 mid-operation with 5 entries busy -> exe_valid=0, rs_count=0 immediately. After release, no dispatch until an issue arrives.
- Oldest-first: issue ROB 3 (dep on ROB 9), then ROB 4 and ROB 5 (ready); exe_ready=1 -> dispatch 4 then 5. Broadcast ROB 9 value 0xDEAD on ch1 -> ROB 3 dispatches one cycle later with val1=0xDEAD.
- Bypass: issue with dep1=7 while cdb ch0 broadcasts ROB 7 = 0x1234 in the same cycle -> dispatch next cycle with val1=0x1234.
- Backpressure: exe_ready=0 for 4 cycles with 3 ready entries -> exe_* stable; rs_count stays 2 after the first load, then drains one per cycle.
- Full: fill DEPTH-1 entries -> rs_full=1 (FULL_MARGIN=1). Simultaneous issue+dispatch keeps rs_count constant; an issue at rs_count==DEPTH is dropped.
- Flush: flush with 6 busy entries, exe_valid=1 and a concurrent issue -> next cycle rs_count=0, exe_valid=0, issue discarded.
